reversible_alu_seq: RTL and testbench

Parametrised, slice-serial successor to the 32-bit reversible-gate ALU. It processes a WIDTH-bit operation SLICE bits per clock, using a registered carry between slices. It uses valid/ready handshakes on both input and output and produces full status flags. The block sits between the operand/opcode source and the result consumer. Its per-bit datapath is built from the team's Feynman, Toffoli, Peres and Fredkin gate primitives.

---
 rtl/reversible_alu_seq.sv | 208 ++++++++++++++++++++
 tb/tb_reversible_alu_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/reversible_alu_seq.sv
// Slice-serial ALU: one SLICE-bit slice of a WIDTH-bit operation per clock, with a
// registered inter-slice carry and valid/ready handshakes on both sides.
module reversible_alu_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       sel,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] F,
   output logic             Cout,
   output logic             zero,
   output logic             ovf
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Reversible gate primitives, reduced to the outputs the datapath consumes.
   function automatic logic feynman(input logic a, input logic b);
      return a ^ b;
   endfunction

   function automatic logic toffoli(input logic a, input logic b, input logic c);
      return c ^ (a & b);
   endfunction

   // Returns {Q, R} = {a^b, c^(a&b)}
   function automatic logic [1:0] peres(input logic a, input logic b, input logic c);
      return {a ^ b, c ^ (a & b)};
   endfunction

   // Controlled-swap Q output: passes a when c=0, b when c=1
   function automatic logic fredkin(input logic c, input logic a, input logic b);
      return c ? b : a;
   endfunction

   function automatic logic is_arith(input logic [3:0] op);
      return (op == 4'd3) || (op == 4'd4) || ((op >= 4'd7) && (op <= 4'd10));
   endfunction

   function automatic logic is_incdec(input logic [3:0] op);
      return (op >= 4'd7) && (op <= 4'd10);
   endfunction

   state_t            state_reg;
   logic              in_ready_reg, out_valid_reg;
   logic [WIDTH-1:0]  a_reg, b_reg, f_reg;
   logic [3:0]        op_reg;
   logic              cin_reg, carry_reg, zacc_reg;
   logic              cout_reg, zero_reg, ovf_reg;
   logic [KW-1:0]     k_reg;

   logic [WIDTH-1:0]  x_full, y_full, shl_full, shr_full;
   logic [SLICE-1:0]  xs, ys, as, bs, shl_s, shr_s;
   logic [SLICE-1:0]  sum_s, and_s, or_s, xor_s, nand_s, nor_s, xnor_s, sh_s;
   logic [SLICE-1:0]  res_s;
   logic [SLICE:0]    carry_c;
   logic              last_slice;

   // Full-width adder operands and shift sources; the slice is cut out below so
   // shifts see their neighbour bits across slice boundaries.
   always_comb begin
      x_full = a_reg;
      y_full = b_reg;
      case (op_reg)
         4'd4:    y_full = ~b_reg;
         4'd7:    y_full = WIDTH'(1);
         4'd8:    y_full = '1;
         4'd9:    begin x_full = b_reg; y_full = WIDTH'(1); end
         4'd10:   begin x_full = b_reg; y_full = '1; end
         default: ;
      endcase
      shl_full = {a_reg[WIDTH-2:0], cin_reg};
      shr_full = {cin_reg, a_reg[WIDTH-1:1]};
   end

   always_comb begin
      xs    = x_full[k_reg*SLICE +: SLICE];
      ys    = y_full[k_reg*SLICE +: SLICE];
      as    = a_reg[k_reg*SLICE +: SLICE];
      bs    = b_reg[k_reg*SLICE +: SLICE];
      shl_s = shl_full[k_reg*SLICE +: SLICE];
      shr_s = shr_full[k_reg*SLICE +: SLICE];
   end

   assign carry_c[0] = carry_reg;

   generate
      for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
         logic [1:0] pg, sc;
         // Two cascaded Peres gates form a full adder: {propagate, generate}, then {sum, carry}.
         assign pg            = peres(xs[gi], ys[gi], 1'b0);
         assign sc            = peres(pg[1], carry_c[gi], pg[0]);
         assign sum_s[gi]     = sc[1];
         assign carry_c[gi+1] = sc[0];

         assign and_s[gi]  = toffoli(as[gi], bs[gi], 1'b0);
         assign nand_s[gi] = toffoli(as[gi], bs[gi], 1'b1);
         assign xor_s[gi]  = feynman(as[gi], bs[gi]);
         assign xnor_s[gi] = feynman(xor_s[gi], 1'b1);
         assign or_s[gi]   = toffoli(as[gi], bs[gi], xor_s[gi]);
         assign nor_s[gi]  = feynman(or_s[gi], 1'b1);
         assign sh_s[gi]   = fredkin(op_reg[0], shr_s[gi], shl_s[gi]);
      end
   endgenerate

   always_comb begin
      res_s = '0;
      case (op_reg)
         4'd0:                         res_s = and_s;
         4'd1:                         res_s = or_s;
         4'd2:                         res_s = xor_s;
         4'd3, 4'd4, 4'd7, 4'd8,
         4'd9, 4'd10:                  res_s = sum_s;
         4'd5, 4'd6:                   res_s = sh_s;
         4'd11:                        res_s = as;
         4'd12:                        res_s = nand_s;
         4'd13:                        res_s = nor_s;
         4'd14:                        res_s = xnor_s;
         default:                      res_s = '0;
      endcase
   end

   assign last_slice = (k_reg == KW'(NSLICE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         a_reg         <= '0;
         b_reg         <= '0;
         f_reg         <= '0;
         op_reg        <= 4'd0;
         cin_reg       <= 1'b0;
         carry_reg     <= 1'b0;
         zacc_reg      <= 1'b0;
         cout_reg      <= 1'b0;
         zero_reg      <= 1'b0;
         ovf_reg       <= 1'b0;
         k_reg         <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg        <= A;
                  b_reg        <= B;
                  op_reg       <= sel;
                  cin_reg      <= Cin;
                  carry_reg    <= is_incdec(sel) ? 1'b0 : Cin;
                  k_reg        <= '0;
                  f_reg        <= '0;
                  zacc_reg     <= 1'b1;
                  zero_reg     <= 1'b0;
                  cout_reg     <= 1'b0;
                  ovf_reg      <= 1'b0;
                  in_ready_reg <= 1'b0;
                  state_reg    <= RUN;
               end
            end
            RUN: begin
               f_reg[k_reg*SLICE +: SLICE] <= res_s;
               carry_reg                   <= carry_c[SLICE];
               zacc_reg                    <= zacc_reg & ~(|res_s);
               if (last_slice) begin
                  zero_reg      <= zacc_reg & ~(|res_s);
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
                  if (is_arith(op_reg)) begin
                     cout_reg <= carry_c[SLICE];
                     ovf_reg  <= carry_c[SLICE] ^ carry_c[SLICE-1];
                  end else if ((op_reg == 4'd5) || (op_reg == 4'd6)) begin
                     cout_reg <= op_reg[0] ? a_reg[WIDTH-1] : a_reg[0];
                  end
               end else begin
                  k_reg <= k_reg + KW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign F         = f_reg;
   assign Cout      = cout_reg;
   assign zero      = zero_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_reversible_alu_seq.sv
// Directed bench for reversible_alu_seq: a 32/8 serial instance and a 16/16 single-cycle instance.
module tb_reversible_alu_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] A, B;
   logic [3:0]  sel;
   logic        Cin;

   logic        iv32, ir32, ov32, ordy32, c32, z32, o32;
   logic [31:0] f32;
   logic        iv16, ir16, ov16, ordy16, c16, z16, o16;
   logic [15:0] f16;

   reversible_alu_seq #(.WIDTH(32), .SLICE(8)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
      .A(A), .B(B), .sel(sel), .Cin(Cin),
      .out_valid(ov32), .out_ready(ordy32),
      .F(f32), .Cout(c32), .zero(z32), .ovf(o32)
   );

   reversible_alu_seq #(.WIDTH(16), .SLICE(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
      .A(A[15:0]), .B(B[15:0]), .sel(sel), .Cin(Cin),
      .out_valid(ov16), .out_ready(ordy16),
      .F(f16), .Cout(c16), .zero(z16), .ovf(o16)
   );

   int   tests = 0;
   int   fails = 0;
   logic use16 = 1'b0;

   logic [31:0] f_o;
   logic        ir_o, ov_o, c_o, z_o, o_o;

   always_comb begin
      if (use16) begin
         f_o = {16'h0, f16}; ir_o = ir16; ov_o = ov16; c_o = c16; z_o = z16; o_o = o16;
      end else begin
         f_o = f32; ir_o = ir32; ov_o = ov32; c_o = c32; z_o = z32; o_o = o32;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_iv(input logic v);
      if (use16) iv16 = v; else iv32 = v;
   endtask

   task automatic set_or(input logic v);
      if (use16) ordy16 = v; else ordy32 = v;
   endtask

   // Entered and left at posedge+1. hold>0 keeps out_ready low that many cycles with a competing request.
   task automatic run_op(input string name, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] b, input logic ci, input logic [31:0] ef,
                         input logic ec, input logic ez, input logic eo,
                         input int lat, input int hold);
      int cycles;
      check({name, " in_ready"}, 32'(ir_o), 32'd1);
      A = a; B = b; sel = s; Cin = ci;
      set_iv(1'b1);
      @(posedge clk); #1;
      set_iv(1'b0);
      A = $urandom; B = $urandom; sel = 4'(s + 4'd1); Cin = ~ci;
      cycles = 0;
      while (!ov_o && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
      end
      check({name, " latency"}, 32'(cycles), 32'(lat));
      check({name, " F"}, f_o, ef);
      check({name, " Cout"}, 32'(c_o), 32'(ec));
      check({name, " zero"}, 32'(z_o), 32'(ez));
      check({name, " ovf"}, 32'(o_o), 32'(eo));
      if (hold > 0) begin
         set_iv(1'b1);
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, " hold F"}, f_o, ef);
            check({name, " hold flags"}, {29'd0, c_o, z_o, o_o}, {29'd0, ec, ez, eo});
            check({name, " hold in_ready"}, 32'(ir_o), 32'd0);
            check({name, " hold out_valid"}, 32'(ov_o), 32'd1);
         end
         set_iv(1'b0);
      end
      set_or(1'b1);
      @(posedge clk); #1;
      set_or(1'b0);
      check({name, " release out_valid"}, 32'(ov_o), 32'd0);
      check({name, " release in_ready"}, 32'(ir_o), 32'd1);
      if (hold > 0) check({name, " no new accept F"}, f_o, ef);
      $display("[TB] %s done: F=0x%08h Cout=%0b zero=%0b ovf=%0b latency=%0d",
               name, f_o, c_o, z_o, o_o, cycles);
   endtask

   // Starts an ADD and resets it while it is still in RUN.
   task automatic rst_run(input string name, input int run_cycles);
      bit seen;
      A = 32'h11111111; B = 32'h22222222; sel = 4'd3; Cin = 1'b0;
      set_iv(1'b1);
      @(posedge clk); #1;
      set_iv(1'b0);
      for (int i = 0; i < run_cycles; i++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check({name, " rst in_ready"}, 32'(ir_o), 32'd1);
      check({name, " rst out_valid"}, 32'(ov_o), 32'd0);
      check({name, " rst F"}, f_o, 32'd0);
      check({name, " rst flags"}, {29'd0, c_o, z_o, o_o}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ov_o) seen = 1'b1;
      end
      check({name, " no result after rst"}, 32'(seen), 32'd0);
      $display("[TB] %s reset mid-RUN done", name);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; iv32 = 1'b0; iv16 = 1'b0; ordy32 = 1'b0; ordy16 = 1'b0;
      A = '0; B = '0; sel = '0; Cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      use16 = 1'b0; #0;
      check("w32 reset in_ready", 32'(ir_o), 32'd1);
      check("w32 reset out_valid", 32'(ov_o), 32'd0);
      check("w32 reset F", f_o, 32'd0);
      check("w32 reset flags", {29'd0, c_o, z_o, o_o}, 32'd0);
      use16 = 1'b1; #0;
      check("w16 reset in_ready", 32'(ir_o), 32'd1);
      check("w16 reset out_valid", 32'(ov_o), 32'd0);
      check("w16 reset F", f_o, 32'd0);
      check("w16 reset flags", {29'd0, c_o, z_o, o_o}, 32'd0);

      use16 = 1'b0;
      //     name            sel    A             B             Cin   F             Co    z     ovf  lat hold
      run_op("w32 ADD wrap", 4'd3,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 4, 0);
      run_op("w32 SUB",      4'd4,  32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 4, 0);
      run_op("w32 ADD ovf",  4'd3,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 4, 0);
      run_op("w32 SHL",      4'd5,  32'h80000001, 32'h00000000, 1'b1, 32'h00000003, 1'b1, 1'b0, 1'b0, 4, 0);
      run_op("w32 SHR",      4'd6,  32'h80000001, 32'h00000000, 1'b0, 32'h40000000, 1'b1, 1'b0, 1'b0, 4, 0);
      run_op("w32 DECA",     4'd8,  32'h00000000, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 4, 0);
      run_op("w32 INCB",     4'd9,  32'h12345678, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 4, 0);
      run_op("w32 NAND",     4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 4, 0);
      run_op("w32 INCA",     4'd7,  32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 1'b0, 1'b0, 4, 0);
      run_op("w32 DECB",     4'd10, 32'h00000000, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 4, 0);
      run_op("w32 AND",      4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 1'b0, 1'b0, 1'b0, 4, 0);
      run_op("w32 OR",       4'd1,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 4, 0);
      run_op("w32 XOR",      4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 4, 0);
      run_op("w32 XNOR",     4'd14, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF00FF00F, 1'b0, 1'b0, 1'b0, 4, 0);
      run_op("w32 NOR",      4'd13, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h000F000F, 1'b0, 1'b0, 1'b0, 4, 0);
      run_op("w32 PASS",     4'd11, 32'hCAFEBABE, 32'h00000000, 1'b1, 32'hCAFEBABE, 1'b0, 1'b0, 1'b0, 4, 0);
      run_op("w32 ZERO",     4'd15, 32'hCAFEBABE, 32'h12345678, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 4, 0);
      run_op("w32 backpres", 4'd3,  32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0, 4, 5);
      rst_run("w32", 1);

      use16 = 1'b1;
      run_op("w16 ADD wrap", 4'd3,  32'h0000FFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1, 0);
      run_op("w16 SUB",      4'd4,  32'h00000005, 32'h00000007, 1'b1, 32'h0000FFFE, 1'b0, 1'b0, 1'b0, 1, 0);
      run_op("w16 ADD ovf",  4'd3,  32'h00007FFF, 32'h00000001, 1'b0, 32'h00008000, 1'b0, 1'b0, 1'b1, 1, 0);
      run_op("w16 SHL",      4'd5,  32'h00008001, 32'h00000000, 1'b1, 32'h00000003, 1'b1, 1'b0, 1'b0, 1, 0);
      run_op("w16 SHR",      4'd6,  32'h00008001, 32'h00000000, 1'b0, 32'h00004000, 1'b1, 1'b0, 1'b0, 1, 0);
      run_op("w16 DECA",     4'd8,  32'h00000000, 32'h00001234, 1'b1, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1, 0);
      run_op("w16 INCB",     4'd9,  32'h00001234, 32'h0000FFFF, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1, 0);
      run_op("w16 NAND",     4'd12, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1, 0);
      run_op("w16 backpres", 4'd2,  32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h00000FF0, 1'b0, 1'b0, 1'b0, 1, 5);
      rst_run("w16", 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
